// File: rtl/jbi_ncio_prtq_ctl.sv
// PRTQ control: pointers/occupancy for the 16-entry RF plus a 2-entry output skid.
// Optional high-water-mark tracking is built when JBI_PRTQ_HWM_EN is defined.
module jbi_ncio_prtq_ctl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 132
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              prtq_full,
  output logic [ADDR_W:0]   prtq_level,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  input  logic              pop,
  output logic              prtq_csn_wr,
  output logic [ADDR_W-1:0] prtq_waddr,
  output logic [DATA_W-1:0] prtq_wdata,
  output logic              prtq_csn_rd,
  output logic [ADDR_W-1:0] prtq_raddr,
  input  logic [DATA_W-1:0] prtq_rdata,
  output logic              prtq_err_ovf,
  output logic              prtq_err_unf
`ifdef JBI_PRTQ_HWM_EN
  ,
  input  logic              hwm_clr,
  output logic [ADDR_W:0]   prtq_hwm
`endif
);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   arr_cnt;
  logic              inflight;
  logic [1:0]        ob_cnt;
  logic [DATA_W-1:0] ob0;
  logic [DATA_W-1:0] ob1;
  logic [2:0]        pend;
  logic              do_wr;
  logic              do_rd;
  logic              do_pop;

  // arr_cnt never exceeds the depth, so its MSB alone marks full
  assign prtq_full  = arr_cnt[ADDR_W];
  assign prtq_level = arr_cnt;
  assign out_vld    = (ob_cnt != 2'd0);
  assign out_data   = ob0;
  assign do_pop     = pop & out_vld;
  assign do_wr      = push & ~prtq_full;

  // entries the skid will hold once the current read/pop settle
  assign pend  = {1'b0, ob_cnt} + {2'b0, inflight} - {2'b0, do_pop};
  assign do_rd = (arr_cnt != '0) & (pend < 3'd2);

  assign prtq_csn_wr = ~(do_wr & rst_l);
  assign prtq_csn_rd = ~(do_rd & rst_l);
  assign prtq_waddr  = wptr;
  assign prtq_raddr  = rptr;
  assign prtq_wdata  = push_data;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr     <= '0;
      rptr     <= '0;
      arr_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      inflight <= do_rd;
      unique case (1'b1)
        do_wr & ~do_rd: arr_cnt <= arr_cnt + 1'b1;
        do_rd & ~do_wr: arr_cnt <= arr_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ob_cnt <= '0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      ob_cnt <= ob_cnt + {1'b0, inflight} - {1'b0, do_pop};
      if (do_pop) begin
        if (ob_cnt == 2'd2) begin
          ob0 <= ob1;
          if (inflight) ob1 <= prtq_rdata;
        end else if (inflight) begin
          ob0 <= prtq_rdata;
        end
      end else if (inflight) begin
        if (ob_cnt == 2'd0) ob0 <= prtq_rdata;
        else                ob1 <= prtq_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      prtq_err_ovf <= 1'b0;
      prtq_err_unf <= 1'b0;
    end else begin
      if (push & prtq_full) prtq_err_ovf <= 1'b1;
      if (pop & ~out_vld)   prtq_err_unf <= 1'b1;
    end
  end

`ifdef JBI_PRTQ_HWM_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      prtq_hwm <= '0;
    end else if (hwm_clr) begin
      prtq_hwm <= arr_cnt;
    end else if (arr_cnt > prtq_hwm) begin
      prtq_hwm <= arr_cnt;
    end
  end
`endif

endmodule
